ex_commit_buffer: RTL and testbench
===================================

Name: ex_commit_buffer

Overview:
- Sits directly downstream of the execute-stage ALU. It captures the ALU result and flags together with the instruction's control sideband.
- Resolves branches and jumps from the ALU flags and drives a one-cycle fetch redirect.
- Buffers results in a 2-entry skid FIFO with valid/ready handshakes toward the memory stage.
- Decouples ALU timing from memory-stage backpressure without losing throughput.

Parameters:
- XLEN, 32, datapath width of result, store data and PCs
- RADDR_W, 5, destination register index width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  drop all buffered entries and any same-cycle input
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  buffer can accept; registered, equals (count<2)
- alu_q  in  XLEN  ALU result Q
- alu_zero  in  1  ALU Zero flag
- alu_neg  in  1  ALU Neg flag (carried for debug/trace)
- br_type  in  br_type_e  branch/jump kind
- pc_plus4  in  XLEN  link value for jumps
- br_target  in  XLEN  precomputed branch/jump target
- rd  in  RADDR_W  destination register
- reg_write, mem_read, mem_write  in  1 each  control sideband
- store_data  in  XLEN  rs2 data for stores
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage accepts head
- out_result, out_store_data  out  XLEN  head fields
- out_rd  out  RADDR_W; out_reg_write, out_mem_read, out_mem_write  out  1 each
- redirect_valid  out  1  one-cycle pulse, taken branch/jump
- redirect_pc  out  XLEN  fetch redirect target

Behaviour:
- Reset: count=0, rd/wr pointers=0, out_valid=0, in_ready=1, redirect_valid=0, redirect_pc=0. All out_* data fields read 0 while empty.
- Handshakes:
  - accept = in_valid & in_ready & !flush
  - emit = out_valid & out_ready
  - simultaneous accept and emit: count unchanged, both pointers advance (1-bit wrap 1->0)
- Storage: 2-entry FIFO, head drives out_* combinationally from storage. out_valid = (count!=0). Zero-bubble: an entry accepted at edge N is visible on out_valid after edge N.
- Result select: out_result field stored as pc_plus4 when br_type is BR_JAL or BR_JALR, else alu_q.
- Branch resolution (combinational on input, registered into redirect):
  - BR_EQ: taken = alu_zero (ALU performs SUB)
  - BR_NE: taken = !alu_zero
  - BR_LT, BR_LTU: taken = alu_q[0] (ALU performs SLT/SLTU)
  - BR_GE, BR_GEU: taken = !alu_q[0]
  - BR_JAL, BR_JALR: taken = 1
  - BR_NONE: taken = 0
  - On accept & taken: next cycle redirect_valid=1 and redirect_pc=br_target. Otherwise redirect_valid=0 and redirect_pc holds.
  - A stalled input (in_valid & !in_ready) never redirects; the redirect fires only on the accepting edge.
- Flush: synchronous with clk. It clears count and pointers, forces redirect_valid=0 next cycle, and drops the same-cycle input. Flush overrides accept and emit. Emit handshake in the flush cycle is still honoured by the consumer (data already presented).
- Full: count=2 gives in_ready=0. in_ready rises the cycle after an emit with no accept.
- Reset mid-operation: immediate return to reset state; redirect_valid drops asynchronously.
- Count never exceeds 2 or underflows; assertion-checked in simulation.

Decomposition:
- control_pkg gains br_type_e (BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR) and a packed ex_mem_t struct (result, store_data, rd, reg_write, mem_read, mem_write).
- One sub-module: branch_resolve (combinational: br_type, alu_q, alu_zero -> taken). Reused by the trace checker.
- FIFO storage and pointer logic stay inline.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, redirect_valid=0, out_result=0.
- Streaming with out_ready=1: accept ADD with alu_q=0x0000_0007, rd=5, reg_write=1 -> next cycle out_valid=1, out_result=7, out_rd=5. Back-to-back inputs flow one per cycle with count<=1.
- Backpressure: out_ready=0, present 3 inputs (results 1,2,3) -> first two accepted, in_ready=0 after the second. Raise out_ready -> emitted 1 then 2, third accepted only once in_ready=1. Order preserved.
- Branch: BR_EQ, alu_zero=1, br_target=0x0000_0100 -> redirect_valid pulses exactly one cycle with redirect_pc=0x100. BR_NE, alu_zero=1 -> no redirect. BR_LTU, alu_q=1 -> redirect. JAL with pc_plus4=0x24 -> out_result=0x24.
- Flush with count=2 and in_valid=1 with a taken branch -> count=0 and out_valid=0 next cycle, no redirect, input dropped.
- Async reset asserted mid-cycle with count=1 and redirect_valid=1 -> outputs go to reset values before the next clk edge.

Source files
------------

// File: rtl/ex_commit_buffer_pkg.sv
// Shared types for the execute-to-memory commit buffer: branch kinds, the buffered entry and widths.
// Pure declarations; no timing or flow control of its own.
package ex_commit_buffer_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [3:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU,
        BR_JAL,
        BR_JALR
    } br_type_e;

    typedef struct packed {
        logic [XLEN-1:0]    result;
        logic [XLEN-1:0]    store_data;
        logic [RADDR_W-1:0] rd;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } ex_mem_t;

    function automatic logic is_jump(br_type_e t);
        return (t == BR_JAL) || (t == BR_JALR);
    endfunction

endpackage

// File: rtl/ex_commit_buffer_if.sv
// Bundles the execute-side input, memory-side output and fetch-redirect signals of the commit buffer.
// slave = the buffer itself, master = the surrounding pipeline (or a bench).
interface ex_commit_buffer_if;
    import ex_commit_buffer_pkg::*;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    alu_q;
    logic               alu_zero;
    logic               alu_neg;
    br_type_e           br_type;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    br_target;
    logic [RADDR_W-1:0] rd;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [XLEN-1:0]    store_data;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_result;
    logic [XLEN-1:0]    out_store_data;
    logic [RADDR_W-1:0] out_rd;
    logic               out_reg_write;
    logic               out_mem_read;
    logic               out_mem_write;

    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;

    modport slave (
        input  flush, in_valid, alu_q, alu_zero, alu_neg, br_type, pc_plus4, br_target,
               rd, reg_write, mem_read, mem_write, store_data, out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
               out_mem_read, out_mem_write, redirect_valid, redirect_pc
    );

    modport master (
        output flush, in_valid, alu_q, alu_zero, alu_neg, br_type, pc_plus4, br_target,
               rd, reg_write, mem_read, mem_write, store_data, out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
               out_mem_read, out_mem_write, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ex_commit_buffer_branch_resolve.sv
// Decides whether a branch/jump is taken from the ALU flags; purely combinational, no backpressure.
// Compares arrive as SUB (zero flag) or SLT/SLTU (result LSB).
module ex_commit_buffer_branch_resolve
    import ex_commit_buffer_pkg::*;
(
    input  br_type_e br_type,
    input  logic     alu_q_lsb,
    input  logic     alu_zero,
    output logic     taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_EQ:            taken = alu_zero;
            BR_NE:            taken = ~alu_zero;
            BR_LT, BR_LTU:    taken = alu_q_lsb;
            BR_GE, BR_GEU:    taken = ~alu_q_lsb;
            BR_JAL, BR_JALR:  taken = 1'b1;
            default:          taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_commit_buffer.sv
// Commit buffer between ALU and memory stage: 2-entry FIFO, result visible one edge after accept, redirect one cycle after a taken accept.
// in_ready is registered (count<2), so full throughput holds with a consumer that keeps up; a stalled input is simply not accepted.
module ex_commit_buffer
    import ex_commit_buffer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    ex_commit_buffer_if.slave   bus
);

    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            in_ready_q, in_ready_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    ex_mem_t         mem_q [2];
    ex_mem_t         mem_d [2];

    logic            taken;
    logic            accept;
    logic            emit;
    logic            out_valid;
    ex_mem_t         in_ent;
    ex_mem_t         head;

    // Neg flag only travels with the instruction for trace; nothing here consumes it.
    logic            unused_alu_neg;
    assign unused_alu_neg = bus.alu_neg;

    ex_commit_buffer_branch_resolve u_branch_resolve (
        .br_type   (bus.br_type),
        .alu_q_lsb (bus.alu_q[0]),
        .alu_zero  (bus.alu_zero),
        .taken     (taken)
    );

    always_comb begin
        in_ent            = '0;
        in_ent.result     = is_jump(bus.br_type) ? bus.pc_plus4 : bus.alu_q;
        in_ent.store_data = bus.store_data;
        in_ent.rd         = bus.rd;
        in_ent.reg_write  = bus.reg_write;
        in_ent.mem_read   = bus.mem_read;
        in_ent.mem_write  = bus.mem_write;

        out_valid = (count_q != 2'd0);
        accept    = bus.in_valid & in_ready_q & ~bus.flush;
        emit      = out_valid & bus.out_ready;

        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_d     = mem_q;

        if (accept) begin
            mem_d[wr_ptr_q] = in_ent;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (emit) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept, emit})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // The consumer may still take the head during a flush; the buffer just forgets everything.
        if (bus.flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end

        in_ready_d       = (count_d != 2'd2);
        redirect_valid_d = accept & taken;
        redirect_pc_d    = (accept & taken) ? bus.br_target : redirect_pc_q;

        head = out_valid ? mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q          <= 2'd0;
            wr_ptr_q         <= 1'b0;
            rd_ptr_q         <= 1'b0;
            in_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mem_q[0]         <= '0;
            mem_q[1]         <= '0;
        end else begin
            count_q          <= count_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            in_ready_q       <= in_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            mem_q[0]         <= mem_d[0];
            mem_q[1]         <= mem_d[1];
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_result     = head.result;
    assign bus.out_store_data = head.store_data;
    assign bus.out_rd         = head.rd;
    assign bus.out_reg_write  = head.reg_write;
    assign bus.out_mem_read   = head.mem_read;
    assign bus.out_mem_write  = head.mem_write;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

    // A 2-bit count that underflows wraps to 3, so this bound also catches underflow.
    count_bound_a: assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);

endmodule

// File: tb/tb_ex_commit_buffer.sv
module tb_ex_commit_buffer;
    import ex_commit_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_commit_buffer_if bus ();

    ex_commit_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic               in_valid;
        logic               out_ready;
        logic               flush;
        logic [XLEN-1:0]    alu_q;
        logic               zero;
        logic               neg;
        br_type_e           bt;
        logic [XLEN-1:0]    pc4;
        logic [XLEN-1:0]    tgt;
        logic [XLEN-1:0]    sd;
        logic [RADDR_W-1:0] rd;
        logic               rw;
        logic               mr;
        logic               mw;
    } stim_t;

    int tests = 0;
    int fails = 0;

    // Reference model: the queue of entries the memory stage should see, plus the redirect register.
    ex_mem_t         exp_q[$];
    bit              pend_push  = 1'b0;
    bit              pend_flush = 1'b0;
    bit              pend_rv    = 1'b0;
    ex_mem_t         pend_ent;
    logic [XLEN-1:0] pend_rpc   = '0;
    bit              m_rv       = 1'b0;
    logic [XLEN-1:0] m_rpc      = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input br_type_e t, input logic [XLEN-1:0] q, input logic z);
        case (t)
            BR_EQ:           return z;
            BR_NE:           return !z;
            BR_LT, BR_LTU:   return q[0];
            BR_GE, BR_GEU:   return !q[0];
            BR_JAL, BR_JALR: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic ex_mem_t ref_entry(input stim_t s);
        ex_mem_t e;
        e.result     = (s.bt == BR_JAL || s.bt == BR_JALR) ? s.pc4 : s.alu_q;
        e.store_data = s.sd;
        e.rd         = s.rd;
        e.reg_write  = s.rw;
        e.mem_read   = s.mr;
        e.mem_write  = s.mw;
        return e;
    endfunction

    function automatic stim_t idle(input bit ordy);
        stim_t s;
        s.in_valid = 1'b0; s.out_ready = ordy; s.flush = 1'b0;
        s.alu_q = '0; s.zero = 1'b0; s.neg = 1'b0; s.bt = BR_NONE;
        s.pc4 = '0; s.tgt = '0; s.sd = '0; s.rd = '0;
        s.rw = 1'b0; s.mr = 1'b0; s.mw = 1'b0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.in_valid  = ($urandom_range(0, 9) < 7);
        s.out_ready = ($urandom_range(0, 9) < 6);
        s.flush     = ($urandom_range(0, 19) == 0);
        s.alu_q     = $urandom;
        s.zero      = $urandom_range(0, 1) == 1;
        s.neg       = $urandom_range(0, 1) == 1;
        s.bt        = br_type_e'(4'($urandom_range(0, 8)));
        s.pc4       = $urandom;
        s.tgt       = $urandom;
        s.sd        = $urandom;
        s.rd        = RADDR_W'($urandom_range(0, 31));
        s.rw        = $urandom_range(0, 1) == 1;
        s.mr        = $urandom_range(0, 1) == 1;
        s.mw        = $urandom_range(0, 1) == 1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.in_valid   = s.in_valid;
        bus.out_ready  = s.out_ready;
        bus.flush      = s.flush;
        bus.alu_q      = s.alu_q;
        bus.alu_zero   = s.zero;
        bus.alu_neg    = s.neg;
        bus.br_type    = s.bt;
        bus.pc_plus4   = s.pc4;
        bus.br_target  = s.tgt;
        bus.store_data = s.sd;
        bus.rd         = s.rd;
        bus.reg_write  = s.rw;
        bus.mem_read   = s.mr;
        bus.mem_write  = s.mw;
    endtask

    task automatic apply_pending();
        if (pend_flush)     exp_q.delete();
        else if (pend_push) exp_q.push_back(pend_ent);
        m_rv = pend_rv;
        if (pend_rv) m_rpc = pend_rpc;
        pend_push = 1'b0; pend_flush = 1'b0; pend_rv = 1'b0;
    endtask

    task automatic check_state();
        chk("in_ready", bus.in_ready, exp_q.size() < 2);
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        chk("redirect_valid", bus.redirect_valid, m_rv);
        chk("redirect_pc", bus.redirect_pc, m_rpc);
        if (exp_q.size() == 0) begin
            chk("empty_out_result", bus.out_result, 0);
            chk("empty_out_rd", bus.out_rd, 0);
        end
    endtask

    // One clock: commit the model's view of the previous edge, check, then drive new inputs.
    task automatic cycle(input stim_t s, output bit acc);
        @(posedge clk);
        apply_pending();
        #1;
        check_state();
        drive(s);
        acc        = s.in_valid && (exp_q.size() < 2) && !s.flush;
        pend_push  = acc;
        pend_ent   = ref_entry(s);
        pend_flush = s.flush;
        pend_rv    = acc && ref_taken(s.bt, s.alu_q, s.zero);
        pend_rpc   = s.tgt;
    endtask

    // Monitor: every emitted head is compared against the oldest expected entry.
    initial begin : monitor
        ex_mem_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL emit_order: got emit of 0x%0h, expected no entry", bus.out_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_result", bus.out_result, e.result);
                    chk("out_store_data", bus.out_store_data, e.store_data);
                    chk("out_rd", bus.out_rd, e.rd);
                    chk("out_ctrl", {bus.out_reg_write, bus.out_mem_read, bus.out_mem_write},
                        {e.reg_write, e.mem_read, e.mem_write});
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        bit    acc;
        int    idx;

        drive(idle(1'b0));
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Reset state, idle
        repeat (2) cycle(idle(1'b0), acc);

        // Streaming with out_ready held high
        s = idle(1'b1); s.in_valid = 1'b1; s.alu_q = 32'h0000_0007; s.rd = 5'd5; s.rw = 1'b1;
        cycle(s, acc);
        for (int i = 0; i < 6; i++) begin
            s = rand_stim(); s.in_valid = 1'b1; s.out_ready = 1'b1; s.flush = 1'b0;
            cycle(s, acc);
        end
        cycle(idle(1'b1), acc);

        // Backpressure: three results, consumer stalled for the first cycles
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            s = idle(c >= 4);
            if (idx < 3) begin
                s.in_valid = 1'b1; s.alu_q = XLEN'(idx + 1); s.rd = RADDR_W'(idx + 1); s.rw = 1'b1;
            end
            cycle(s, acc);
            if (acc) idx++;
        end

        // Branch cases
        s = idle(1'b1); s.in_valid = 1'b1; s.bt = BR_EQ; s.zero = 1'b1; s.tgt = 32'h0000_0100;
        cycle(s, acc); cycle(idle(1'b1), acc); cycle(idle(1'b1), acc);
        s = idle(1'b1); s.in_valid = 1'b1; s.bt = BR_NE; s.zero = 1'b1; s.tgt = 32'h0000_0200;
        cycle(s, acc); cycle(idle(1'b1), acc);
        s = idle(1'b1); s.in_valid = 1'b1; s.bt = BR_LTU; s.alu_q = 32'h1; s.tgt = 32'h0000_0300;
        cycle(s, acc); cycle(idle(1'b1), acc);
        s = idle(1'b1); s.in_valid = 1'b1; s.bt = BR_JAL; s.pc4 = 32'h24; s.alu_q = 32'hdead;
        s.tgt = 32'h0000_0400; s.rd = 5'd1; s.rw = 1'b1;
        cycle(s, acc); cycle(idle(1'b1), acc); cycle(idle(1'b1), acc);

        // Flush while full with a taken jump on the input
        for (int i = 0; i < 2; i++) begin
            s = idle(1'b0); s.in_valid = 1'b1; s.alu_q = XLEN'(32'h50 + i);
            cycle(s, acc);
        end
        s = idle(1'b0); s.in_valid = 1'b1; s.flush = 1'b1; s.bt = BR_JAL; s.tgt = 32'h0000_0500;
        cycle(s, acc);
        cycle(idle(1'b0), acc);
        cycle(idle(1'b1), acc);

        // Asynchronous reset with one entry held and a redirect pulse live
        s = idle(1'b0); s.in_valid = 1'b1; s.bt = BR_JAL; s.pc4 = 32'h44; s.tgt = 32'h0000_0600;
        cycle(s, acc);
        cycle(idle(1'b0), acc);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_in_ready", bus.in_ready, 1'b1);
        chk("arst_redirect_valid", bus.redirect_valid, 1'b0);
        chk("arst_redirect_pc", bus.redirect_pc, 0);
        chk("arst_out_result", bus.out_result, 0);
        exp_q.delete();
        m_rv = 1'b0; m_rpc = '0;
        pend_push = 1'b0; pend_flush = 1'b0; pend_rv = 1'b0;
        @(negedge clk) rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(rand_stim(), acc);
        end

        repeat (4) cycle(idle(1'b1), acc);
        chk("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
